dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the pipeline's load/store path.
- Accepts one request at a time from the execute stage: address, store data, funct3, store flag.
- Performs a word-organised RAM access after a fixed latency and returns read data aligned the way the load path consumes it:
  - addressed byte left-justified in [31:24];
  - addressed halfword left-justified in [31:16].

Parameters:
- XLEN, 32, width of address and store data.
- DEPTH_WORDS, 256, RAM depth in 32-bit words (power of two, ≥4).
- LATENCY, 2, cycles from request acceptance to resp_valid (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data; the low byte, half or word is used.
- resp_valid  out  1  one-cycle pulse; the response is complete.
- resp_data  out  32  load data, aligned as described in Behaviour.
- resp_err  out  1  valid with resp_valid; misaligned access.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; req_ready=1, resp_valid=0, resp_data=0, resp_err=0; latency counter = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&req_ready, latch store, funct3, addr and wdata, and load counter = LATENCY-1.
    - Next state is RESP if LATENCY==1, otherwise WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle; go to RESP when the counter reaches 1.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
  - A new request can be accepted in the cycle after RESP.
  - Request-to-response latency is exactly LATENCY cycles: accept at edge N, resp_valid high during cycle N+LATENCY.
- Address mapping:
  - Word index = addr[log2(DEPTH_WORDS)+1:2]; upper address bits are ignored, so addresses wrap.
  - off = addr[1:0].
- Byte lanes are big-endian within a word: byte offset 0 occupies bits [31:24], offset 3 occupies [7:0].
- Misalignment:
  - H/HU/SH with off[0]=1 is misaligned.
  - W/SW with off≠0 is misaligned.
  - Handling depends on the optional feature.
- Loads:
  - resp_data = stored word << (8*off). LW returns the word unchanged.
  - No sign extension is done here; the consumer extends from [31:24] or [31:16].
- Stores:
  - SB writes wdata[7:0] to lane off.
  - SH writes wdata[15:0] to lanes off, off+1.
  - SW writes the whole word.
  - Unselected lanes are preserved.
  - The RAM write commits on the edge entering RESP.
  - The store response has resp_data=0.
- Invalid funct3 (011, 110, 111):
  - Treated as misaligned: resp_err=1, no write, resp_data=0.
- resp_data and resp_err hold their last values after resp_valid drops; they change only on the edge entering RESP, or on reset.
- Reset during WAIT aborts the request: no RAM write, no response.
- Reset asserted in the RESP cycle clears outputs immediately; the write has already committed.
- req_valid in WAIT/RESP is ignored (req_ready=0). The requester must hold its request until accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access responds with resp_err=1 and resp_data=0, does not write RAM, and keeps the same latency.
- Undefined:
  - resp_err is tied to 0.
  - Misaligned addresses are force-aligned by clearing off[0] for H and off[1:0] for W; the access then proceeds normally.
  - Invalid funct3 still gives no write and resp_data=0.

Test Plan:
- Reset, then SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 → resp_data=0xA1B2C3D4; each resp_valid occurs exactly LATENCY=2 cycles after acceptance; req_ready=0 during WAIT/RESP.
- After the above, LB 0x11 → 0xB2C3D400; LH 0x12 → 0xC3D40000; LBU 0x13 → 0xD4000000.
- SB 0x12 data 0x000000EE, then LW 0x10 → 0xA1B2EED4 (other lanes preserved). SH 0x10 data 0x1234, then LW → 0x1234EED4.
- With DMEM_MISALIGN_TRAP_EN: SW 0x11 → resp_err=1 and LW 0x10 is unchanged. Without the macro: LH 0x13 returns the same value as LH 0x12.
- Wrap-around with DEPTH_WORDS=256: SW 0x400 data 0x55AA55AA, then LW 0x000 → 0x55AA55AA.
- SW 0x20 data 0xDEADBEEF, with reset asserted for 1 cycle during WAIT → no resp_valid, req_ready=1 after reset; a later LW 0x20 does not return 0xDEADBEEF (0x20 is preloaded with 0x0 beforehand).

Source files
------------

// File: rtl/dmem_responder.sv
// Word-organised data-memory responder with fixed request-to-response latency.
// Loads return the addressed byte/halfword left-justified. Optional macro: DMEM_MISALIGN_TRAP_EN.
module dmem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [31:0]     resp_data,
  output logic            resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            st_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept, enter_resp;
  logic            cur_st;
  logic [2:0]      cur_f3;
  logic [XLEN-1:0] cur_addr, cur_wdata;
  logic [AW-1:0]   idx;
  logic [1:0]      off, off_eff;
  logic            is_h, is_w, invalid, misal, err_d, do_access;
  logic [3:0]      be;
  logic [31:0]     wd, rdata;
  logic            unused_addr_bits;

  assign accept     = req_valid && (state_q == IDLE);
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: if (cnt_q == CW'(1)) begin
        state_d    = RESP;
        enter_resp = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt_q   <= CW'(LATENCY - 1);
      st_q    <= req_store;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state_q == WAIT) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // With LATENCY==1 the access completes on the accept edge, so use the live request.
  assign cur_st    = (state_q == IDLE) ? req_store  : st_q;
  assign cur_f3    = (state_q == IDLE) ? req_funct3 : f3_q;
  assign cur_addr  = (state_q == IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state_q == IDLE) ? req_wdata  : wdata_q;

  assign idx              = cur_addr[AW+1:2];
  assign off              = cur_addr[1:0];
  assign unused_addr_bits = ^cur_addr[XLEN-1:AW+2];

  always_comb begin
    is_h    = (cur_f3[1:0] == 2'b01);
    is_w    = (cur_f3 == 3'b010);
    invalid = (cur_f3 == 3'b011) || (cur_f3[2:1] == 2'b11);
    misal   = (is_h && off[0]) || (is_w && (off != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
    err_d     = invalid || misal;
    off_eff   = off;
    do_access = !(invalid || misal);
`else
    err_d     = 1'b0;
    off_eff   = is_w ? 2'b00 : (is_h ? {off[1], 1'b0} : off);
    do_access = !invalid;
`endif
    // Big-endian lanes: be[3] is bits [31:24], i.e. byte offset 0.
    if (is_w) begin
      be = 4'b1111;
      wd = cur_wdata[31:0];
    end else if (is_h) begin
      be = 4'b1100 >> off_eff;
      wd = {2{cur_wdata[15:0]}};
    end else begin
      be = 4'b1000 >> off_eff;
      wd = {4{cur_wdata[7:0]}};
    end
    rdata = mem[idx] << {off_eff, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (reset && enter_resp && cur_st && do_access) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else if (enter_resp) begin
      resp_err  <= err_d;
      resp_data <= (cur_st || !do_access) ? 32'h0 : rdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard of expected responses, latency and handshake checks.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    string       tag;
  } exp_t;
  exp_t sb[$];

`ifdef DMEM_MISALIGN_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  dmem_responder #(.XLEN(32), .DEPTH_WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wdat, input logic [31:0] ed, input logic ee,
                        input string tag);
    exp_t x;
    int   k;
    logic [31:0] held;
    @(negedge clk);
    check({tag, "_ready_idle"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wdat;
    @(posedge clk);
    x.d = ed; x.e = ee; x.tag = tag;
    sb.push_back(x);
    #1 req_valid = 1'b0;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (resp_valid) break;
      check({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
    end
    check({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
    check({tag, "_latency"}, k, LAT);
    check({tag, "_ready_resp"}, {31'b0, req_ready}, 32'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      x = sb.pop_front();
      check({x.tag, "_data"}, resp_data, x.d);
      check({x.tag, "_err"}, {31'b0, resp_err}, {31'b0, x.e});
    end
    held = resp_data;
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_hold"}, resp_data, held);
  endtask

  initial begin
    int seen;
    reset = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_data", resp_data, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'd0);
    reset = 1'b1;

    do_req(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 32'h0, 1'b0, "sw10");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2C3D4, 1'b0, "lw10");
    do_req(1'b0, 3'b000, 32'h11, 32'h0, 32'hB2C3D400, 1'b0, "lb11");
    do_req(1'b0, 3'b001, 32'h12, 32'h0, 32'hC3D40000, 1'b0, "lh12");
    do_req(1'b0, 3'b100, 32'h13, 32'h0, 32'hD4000000, 1'b0, "lbu13");
    do_req(1'b1, 3'b000, 32'h12, 32'h000000EE, 32'h0, 1'b0, "sb12");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'hA1B2EED4, 1'b0, "lw10_sb");
    do_req(1'b1, 3'b001, 32'h10, 32'h00001234, 32'h0, 1'b0, "sh10");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234EED4, 1'b0, "lw10_sh");
    do_req(1'b0, 3'b101, 32'h12, 32'h0, 32'hEED40000, 1'b0, "lhu12");

`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(1'b1, 3'b010, 32'h11, 32'hDEADBEEF, 32'h0, 1'b1, "sw11_mis");
    do_req(1'b0, 3'b001, 32'h13, 32'h0, 32'h0, 1'b1, "lh13_mis");
`else
    do_req(1'b0, 3'b001, 32'h13, 32'h0, 32'hEED40000, 1'b0, "lh13_align");
    do_req(1'b0, 3'b010, 32'h12, 32'h0, 32'h1234EED4, 1'b0, "lw12_align");
`endif
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234EED4, 1'b0, "lw10_after_mis");
    do_req(1'b1, 3'b011, 32'h10, 32'hFFFFFFFF, 32'h0, TRAP, "inv011");
    do_req(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, TRAP, "inv110");
    do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234EED4, 1'b0, "lw10_after_inv");

    do_req(1'b1, 3'b010, 32'h400, 32'h55AA55AA, 32'h0, 1'b0, "sw400");
    do_req(1'b0, 3'b010, 32'h000, 32'h0, 32'h55AA55AA, 1'b0, "lw000_wrap");

    do_req(1'b1, 3'b010, 32'h20, 32'h00000000, 32'h0, 1'b0, "sw20_pre");
    @(negedge clk);
    check("abort_ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_in_wait", {31'b0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("abort_rst_ready", {31'b0, req_ready}, 32'd1);
    check("abort_rst_valid", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("abort_no_resp", seen, 0);
    check("abort_ready_after", {31'b0, req_ready}, 32'd1);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, 32'h00000000, 1'b0, "lw20_abort");

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
